conv_accelerator: RTL and testbench

- Single-output-channel 2-D convolution engine for the CNN datapath.
- Streams the input feature map (IF) and weights (W) from a shared off-chip word memory.
- Multiply-accumulates one product per cycle.
- Writes each output feature map (OF) element back to the same memory, then raises FINISHED until software acknowledges.

---
 rtl/conv_accelerator.sv | 262 ++++++++++++++++++++++++++
 tb/tb_conv_accelerator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_accelerator.sv
// conv_accelerator: single-output-channel 2-D convolution engine that streams IF/W from a shared word memory.
// Optional feature: define ACCELERATOR_RELU_EN to clamp negative saturated results to 0 before write-back.
//
// state  | meaning
// IDLE   | waiting for START
// CHECK  | latch configuration, reject invalid shapes, choose weight load or reuse
// LOAD_W | stream Nw weight words into the on-chip buffer (+1 drain cycle)
// CONV   | stream one receptive field, MAC one product per cycle (+1 drain cycle)
// WRITE  | write the saturated OF element, advance j then i
// DONE   | FINISHED held until FINISHED_OK
module conv_accelerator #(
  parameter int BITWIDTH_W_ROWS      = 4,
  parameter int BITWIDTH_W_COLUMS    = 4,
  parameter int BITWIDTH_IF_CHANNELS = 2,
  parameter int BITWIDTH_IF_ROWS     = 10,
  parameter int BITWIDTH_IF_COLUMS   = 11,
  parameter int BITWIDTH_STRIDE      = 4,
  parameter int OFFMEM_ADDR_WIDTH    = 32,
  parameter int OFFMEM_DATA_WIDTH    = 16,
  parameter int MAX_W_WORDS          = 675
) (
  input  logic                            ACCELERATOR_Clk_50,
  input  logic                            ACCELERATOR_Reset,
  input  logic [OFFMEM_DATA_WIDTH-1:0]    ACCELERATOR_DATA_IN,
  input  logic [OFFMEM_ADDR_WIDTH-1:0]    ACCELERATOR_ADDR_OFFSET,
  input  logic [BITWIDTH_IF_ROWS-1:0]     ACCELERATOR_IF_ROWS,
  input  logic [BITWIDTH_IF_COLUMS-1:0]   ACCELERATOR_IF_COLUMS,
  input  logic [BITWIDTH_IF_CHANNELS-1:0] ACCELERATOR_IF_CHANNELS,
  input  logic [BITWIDTH_IF_ROWS-1:0]     ACCELERATOR_OF_ROWS,
  input  logic [BITWIDTH_IF_COLUMS-1:0]   ACCELERATOR_OF_COLUMS,
  input  logic [BITWIDTH_W_ROWS-1:0]      ACCELERATOR_W_ROWS,
  input  logic [BITWIDTH_W_COLUMS-1:0]    ACCELERATOR_W_COLUMS,
  input  logic [BITWIDTH_IF_CHANNELS-1:0] ACCELERATOR_W_CHANNELS,
  input  logic                            ACCELERATOR_SAME_W,
  input  logic [BITWIDTH_STRIDE-1:0]      ACCELERATOR_CONV_STRIDE,
  input  logic                            ACCELERATOR_START,
  input  logic                            ACCELERATOR_FINISHED_OK,
  output logic [OFFMEM_DATA_WIDTH-1:0]    ACCELERATOR_DATA_OUT,
  output logic [OFFMEM_ADDR_WIDTH-1:0]    ACCELERATOR_MEM_ADDR,
  output logic                            ACCELERATOR_MEM_WE,
  output logic                            ACCELERATOR_MEM_RE,
  output logic                            ACCELERATOR_FINISHED
);

  localparam int AW     = OFFMEM_ADDR_WIDTH;
  localparam int DW     = OFFMEM_DATA_WIDTH;
  localparam int ACC_W  = 2*OFFMEM_DATA_WIDTH + 8;
  localparam int WIDX_W = $clog2(MAX_W_WORDS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_LOAD_W = 3'd2;
  localparam logic [2:0] S_CONV   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]                    state_q, state_d;
  logic                          wvalid_q, wvalid_d;
  logic [AW-1:0]                 ifc_q, ifc_d, plane_q, plane_d, srow_q, srow_d, s_q, s_d;
  logic [BITWIDTH_W_ROWS-1:0]    wr_q, wr_d;
  logic [BITWIDTH_W_COLUMS-1:0]  wc_q, wc_d;
  logic [BITWIDTH_IF_ROWS-1:0]   ofr_q, ofr_d, i_q, i_d;
  logic [BITWIDTH_IF_COLUMS-1:0] ofc_q, ofc_d, j_q, j_d;
  logic [WIDX_W-1:0]             nw_q, nw_d, cnt_q, cnt_d, widx_q, widx_d, lag_idx_q, lag_idx_d;
  logic [BITWIDTH_W_ROWS-1:0]    r_q, r_d;
  logic [BITWIDTH_W_COLUMS-1:0]  k_q, k_d;
  logic [AW-1:0]                 rd_addr_q, rd_addr_d, row_ptr_q, row_ptr_d, ch_ptr_q, ch_ptr_d;
  logic [AW-1:0]                 pix_q, pix_d, rowb_q, rowb_d, of_addr_q, of_addr_d;
  logic                          mac_v_q, mac_v_d;
  logic signed [DW-1:0]          w_q, w_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;

  logic signed [DW-1:0]          wbuf [MAX_W_WORDS];

  // Shape products are formed once per run in CHECK and registered; the per-cycle address path only adds.
  logic [WIDX_W-1:0] nw_c;
  logic [AW-1:0]     plane_c, wb_c, ofb_c, srow_c;
  logic              cfg_ok_c, issue_c, start_elem;
  logic [AW-1:0]     pix_n;
  logic [WIDX_W-1:0] nw_n;
  logic signed [2*DW-1:0] prod_c;
  logic [DW-1:0]     sat_c, wr_data_c;
  logic              fits_c;

  assign nw_c    = WIDX_W'(ACCELERATOR_W_CHANNELS) * WIDX_W'(ACCELERATOR_W_ROWS) * WIDX_W'(ACCELERATOR_W_COLUMS);
  assign plane_c = AW'(ACCELERATOR_IF_ROWS) * AW'(ACCELERATOR_IF_COLUMS);
  assign wb_c    = ACCELERATOR_ADDR_OFFSET + AW'(ACCELERATOR_IF_CHANNELS) * plane_c;
  assign ofb_c   = wb_c + AW'(nw_c);
  assign srow_c  = AW'(ACCELERATOR_CONV_STRIDE) * AW'(ACCELERATOR_IF_COLUMS);

  assign cfg_ok_c = (ACCELERATOR_IF_ROWS != '0) && (ACCELERATOR_IF_COLUMS != '0) &&
                    (ACCELERATOR_IF_CHANNELS != '0) && (ACCELERATOR_OF_ROWS != '0) &&
                    (ACCELERATOR_OF_COLUMS != '0) && (ACCELERATOR_W_ROWS != '0) &&
                    (ACCELERATOR_W_COLUMS != '0) && (ACCELERATOR_W_CHANNELS != '0) &&
                    (ACCELERATOR_CONV_STRIDE != '0) &&
                    (ACCELERATOR_W_CHANNELS == ACCELERATOR_IF_CHANNELS);

  assign issue_c = ((state_q == S_LOAD_W) || (state_q == S_CONV)) && (cnt_q != '0);
  assign prod_c  = $signed(ACCELERATOR_DATA_IN) * w_q;

  // Result fits in DW bits when all bits above the DW-1 sign bit agree with it.
  assign fits_c = (&acc_q[ACC_W-1:DW-1]) | ~(|acc_q[ACC_W-1:DW-1]);
  assign sat_c  = fits_c ? acc_q[DW-1:0] :
                  (acc_q[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});

  always_comb begin
`ifdef ACCELERATOR_RELU_EN
    wr_data_c = sat_c[DW-1] ? '0 : sat_c;
`else
    wr_data_c = sat_c;
`endif
  end

  always_comb begin
    state_d   = state_q;   wvalid_d  = wvalid_q;
    ifc_d     = ifc_q;     plane_d   = plane_q;   srow_d = srow_q;  s_d = s_q;
    wr_d      = wr_q;      wc_d      = wc_q;      ofr_d  = ofr_q;   ofc_d = ofc_q;
    nw_d      = nw_q;      cnt_d     = cnt_q;     widx_d = widx_q;
    r_d       = r_q;       k_d       = k_q;       i_d    = i_q;     j_d = j_q;
    rd_addr_d = rd_addr_q; row_ptr_d = row_ptr_q; ch_ptr_d = ch_ptr_q;
    pix_d     = pix_q;     rowb_d    = rowb_q;    of_addr_d = of_addr_q;
    w_d       = w_q;       acc_d     = acc_q;
    mac_v_d   = issue_c;   lag_idx_d = widx_q;
    start_elem = 1'b0;     pix_n     = pix_q;     nw_n   = nw_q;

    case (state_q)
      S_IDLE: if (ACCELERATOR_START) state_d = S_CHECK;
      S_CHECK: begin
        ifc_d   = AW'(ACCELERATOR_IF_COLUMS);
        plane_d = plane_c;
        srow_d  = srow_c;
        s_d     = AW'(ACCELERATOR_CONV_STRIDE);
        wr_d    = ACCELERATOR_W_ROWS;
        wc_d    = ACCELERATOR_W_COLUMS;
        ofr_d   = ACCELERATOR_OF_ROWS;
        ofc_d   = ACCELERATOR_OF_COLUMS;
        nw_d    = nw_c;
        pix_d   = ACCELERATOR_ADDR_OFFSET;
        rowb_d  = ACCELERATOR_ADDR_OFFSET;
        of_addr_d = ofb_c;
        i_d     = '0;
        j_d     = '0;
        acc_d   = '0;
        if (!cfg_ok_c) begin
          state_d = S_DONE;
        end else if (ACCELERATOR_SAME_W && wvalid_q) begin
          state_d    = S_CONV;
          start_elem = 1'b1;
          pix_n      = ACCELERATOR_ADDR_OFFSET;
          nw_n       = nw_c;
        end else begin
          state_d   = S_LOAD_W;
          cnt_d     = nw_c;
          rd_addr_d = wb_c;
          widx_d    = '0;
        end
      end
      S_LOAD_W: begin
        if (issue_c) begin
          cnt_d     = cnt_q - 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          widx_d    = widx_q + 1'b1;
        end else begin
          wvalid_d   = 1'b1;
          state_d    = S_CONV;
          start_elem = 1'b1;
        end
      end
      S_CONV: begin
        if (mac_v_q) acc_d = acc_q + ACC_W'(prod_c);
        if (issue_c) begin
          cnt_d  = cnt_q - 1'b1;
          widx_d = widx_q + 1'b1;
          w_d    = wbuf[widx_q];
          if (k_q != wc_q - 1'b1) begin
            k_d       = k_q + 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
          end else if (r_q != wr_q - 1'b1) begin
            k_d       = '0;
            r_d       = r_q + 1'b1;
            row_ptr_d = row_ptr_q + ifc_q;
            rd_addr_d = row_ptr_q + ifc_q;
          end else begin
            k_d       = '0;
            r_d       = '0;
            ch_ptr_d  = ch_ptr_q + plane_q;
            row_ptr_d = ch_ptr_q + plane_q;
            rd_addr_d = ch_ptr_q + plane_q;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        acc_d     = '0;
        of_addr_d = of_addr_q + 1'b1;
        if (j_q != ofc_q - 1'b1) begin
          j_d        = j_q + 1'b1;
          pix_n      = pix_q + s_q;
          start_elem = 1'b1;
          state_d    = S_CONV;
        end else if (i_q != ofr_q - 1'b1) begin
          j_d        = '0;
          i_d        = i_q + 1'b1;
          rowb_d     = rowb_q + srow_q;
          pix_n      = rowb_q + srow_q;
          start_elem = 1'b1;
          state_d    = S_CONV;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: if (ACCELERATOR_FINISHED_OK) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start_elem) begin
      cnt_d     = nw_n;
      widx_d    = '0;
      k_d       = '0;
      r_d       = '0;
      pix_d     = pix_n;
      rd_addr_d = pix_n;
      row_ptr_d = pix_n;
      ch_ptr_d  = pix_n;
    end
  end

  always_ff @(posedge ACCELERATOR_Clk_50 or negedge ACCELERATOR_Reset) begin
    if (!ACCELERATOR_Reset) begin
      state_q <= S_IDLE;    wvalid_q <= 1'b0;
      ifc_q <= '0;  plane_q <= '0;  srow_q <= '0;  s_q <= '0;
      wr_q <= '0;   wc_q <= '0;     ofr_q <= '0;   ofc_q <= '0;
      nw_q <= '0;   cnt_q <= '0;    widx_q <= '0;  lag_idx_q <= '0;
      r_q <= '0;    k_q <= '0;      i_q <= '0;     j_q <= '0;
      rd_addr_q <= '0; row_ptr_q <= '0; ch_ptr_q <= '0;
      pix_q <= '0;  rowb_q <= '0;   of_addr_q <= '0;
      mac_v_q <= 1'b0; w_q <= '0;   acc_q <= '0;
    end else begin
      state_q <= state_d;   wvalid_q <= wvalid_d;
      ifc_q <= ifc_d;  plane_q <= plane_d;  srow_q <= srow_d;  s_q <= s_d;
      wr_q <= wr_d;    wc_q <= wc_d;        ofr_q <= ofr_d;    ofc_q <= ofc_d;
      nw_q <= nw_d;    cnt_q <= cnt_d;      widx_q <= widx_d;  lag_idx_q <= lag_idx_d;
      r_q <= r_d;      k_q <= k_d;          i_q <= i_d;        j_q <= j_d;
      rd_addr_q <= rd_addr_d; row_ptr_q <= row_ptr_d; ch_ptr_q <= ch_ptr_d;
      pix_q <= pix_d;  rowb_q <= rowb_d;    of_addr_q <= of_addr_d;
      mac_v_q <= mac_v_d; w_q <= w_d;       acc_q <= acc_d;
    end
  end

  // Read data lands one cycle after its request, so the buffer is written with the lagged index.
  always_ff @(posedge ACCELERATOR_Clk_50) begin
    if ((state_q == S_LOAD_W) && mac_v_q) wbuf[lag_idx_q] <= $signed(ACCELERATOR_DATA_IN);
  end

  assign ACCELERATOR_MEM_RE   = issue_c;
  assign ACCELERATOR_MEM_WE   = (state_q == S_WRITE);
  assign ACCELERATOR_MEM_ADDR = issue_c ? rd_addr_q : ((state_q == S_WRITE) ? of_addr_q : '0);
  assign ACCELERATOR_DATA_OUT = (state_q == S_WRITE) ? wr_data_c : '0;
  assign ACCELERATOR_FINISHED = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_accelerator.sv
// Directed self-checking bench for conv_accelerator with a synchronous-read word memory model.
module tb_conv_accelerator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din = 16'h0;
  logic [31:0] off;
  logic [9:0]  ifr, ofr;
  logic [10:0] ifc, ofc;
  logic [1:0]  ifch, wch;
  logic [3:0]  wr, wc, stride;
  logic        same_w, start, fok;
  logic [15:0] dout;
  logic [31:0] addr;
  logic        we, re, fin;

  always #5 clk = ~clk;

  conv_accelerator dut (
    .ACCELERATOR_Clk_50(clk), .ACCELERATOR_Reset(rst_n), .ACCELERATOR_DATA_IN(din),
    .ACCELERATOR_ADDR_OFFSET(off), .ACCELERATOR_IF_ROWS(ifr), .ACCELERATOR_IF_COLUMS(ifc),
    .ACCELERATOR_IF_CHANNELS(ifch), .ACCELERATOR_OF_ROWS(ofr), .ACCELERATOR_OF_COLUMS(ofc),
    .ACCELERATOR_W_ROWS(wr), .ACCELERATOR_W_COLUMS(wc), .ACCELERATOR_W_CHANNELS(wch),
    .ACCELERATOR_SAME_W(same_w), .ACCELERATOR_CONV_STRIDE(stride), .ACCELERATOR_START(start),
    .ACCELERATOR_FINISHED_OK(fok), .ACCELERATOR_DATA_OUT(dout), .ACCELERATOR_MEM_ADDR(addr),
    .ACCELERATOR_MEM_WE(we), .ACCELERATOR_MEM_RE(re), .ACCELERATOR_FINISHED(fin)
  );

  logic [15:0] mem [0:1023];
  always @(posedge clk) if (re) din <= mem[addr];

  int unsigned wlo = 0, whi = 0;
  int n_rd = 0, n_rd_w = 0, n_both = 0;
  logic [31:0] wq_addr [$];
  logic [15:0] wq_data [$];
  always @(negedge clk) begin
    if (re) begin
      n_rd++;
      if (addr >= wlo && addr < whi) n_rd_w++;
    end
    if (we) begin
      wq_addr.push_back(addr);
      wq_data.push_back(dout);
    end
    if (re && we) n_both++;
  end

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int off, ifr, ifc, ifch, ofr, ofc, wr, wc, wch, s, same_w;
    int if_base, if_ramp, w_val, w_one_pos;
    int exp0, expi, expj, exp_wreads;
  } vec_t;

`ifdef ACCELERATOR_RELU_EN
  localparam int NEG_SAT = 0;
`else
  localparam int NEG_SAT = 32'h8000;
`endif

  function automatic vec_t mk(int o, int a, int b, int c, int d, int e, int f, int g, int h, int s,
                              int sw, int ib, int ir, int wv, int wp, int e0, int ei, int ej, int ew);
    vec_t v;
    v.off = o; v.ifr = a; v.ifc = b; v.ifch = c; v.ofr = d; v.ofc = e;
    v.wr = f; v.wc = g; v.wch = h; v.s = s; v.same_w = sw;
    v.if_base = ib; v.if_ramp = ir; v.w_val = wv; v.w_one_pos = wp;
    v.exp0 = e0; v.expi = ei; v.expj = ej; v.exp_wreads = ew;
    return v;
  endfunction

  task automatic setup(input vec_t v);
    int nif, nw, wb;
    nif = v.ifch * v.ifr * v.ifc;
    nw  = v.wch * v.wr * v.wc;
    wb  = v.off + nif;
    for (int a = 0; a < 1024; a++) mem[a] = 16'hDEAD;
    for (int a = 0; a < nif; a++) mem[v.off + a] = 16'(v.if_base + v.if_ramp * a);
    for (int n = 0; n < nw; n++)
      mem[wb + n] = (v.w_one_pos < 0) ? 16'(v.w_val) : ((n == v.w_one_pos) ? 16'd1 : 16'd0);
    wlo = wb; whi = wb + nw;
    off = 32'(v.off); ifr = 10'(v.ifr); ifc = 11'(v.ifc); ifch = 2'(v.ifch);
    ofr = 10'(v.ofr); ofc = 11'(v.ofc); wr = 4'(v.wr); wc = 4'(v.wc); wch = 2'(v.wch);
    stride = 4'(v.s); same_w = v.same_w[0];
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_fin(input int limit, output int cyc);
    cyc = 0;
    while (!fin && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic ack(input string nm);
    repeat (3) @(negedge clk);
    chk({nm, "_fin_held"}, int'(fin), 1);
    fok = 1'b1;
    @(negedge clk) fok = 1'b0;
    chk({nm, "_fin_clr"}, int'(fin), 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int rdw0, wr0, both0, cyc, nw, nel, lat, ofb, ii, jj, e;
    setup(v);
    nw  = v.wch * v.wr * v.wc;
    nel = v.ofr * v.ofc;
    ofb = v.off + v.ifch * v.ifr * v.ifc + nw;
    lat = 1 + ((v.exp_wreads != 0) ? nw + 1 : 0) + nel * (nw + 2);
    rdw0 = n_rd_w; wr0 = wq_addr.size(); both0 = n_both;
    pulse_start();
    wait_fin(5000, cyc);
    chk({nm, "_finished"}, int'(fin), 1);
    chk({nm, "_latency"}, cyc, lat);
    chk({nm, "_wreads"}, n_rd_w - rdw0, v.exp_wreads);
    chk({nm, "_nwrites"}, wq_addr.size() - wr0, nel);
    chk({nm, "_re_we_overlap"}, n_both - both0, 0);
    for (int k = 0; k < nel && wr0 + k < wq_addr.size(); k++) begin
      ii = k / v.ofc;
      jj = k % v.ofc;
      e  = (v.exp0 + v.expi * ii + v.expj * jj) & 32'hFFFF;
      chk($sformatf("%s_addr_%0d_%0d", nm, ii, jj), int'(wq_addr[wr0 + k]), ofb + k);
      chk($sformatf("%s_data_%0d_%0d", nm, ii, jj), int'(wq_data[wr0 + k]), e);
    end
    ack(nm);
  endtask

  vec_t tbl [5];

  initial begin
    vec_t v;
    int rd0, wr0, cyc;
    // off ifr ifc ifch ofr ofc wr wc wch s same | if_base ramp w_val w_pos | exp0 expi expj wreads
    tbl[0] = mk(9, 8, 8, 3, 5, 4, 4, 5, 3, 1, 0,   1,       0, 1,       -1,  60,      0,  0, 60);
    tbl[1] = mk(9, 8, 8, 1, 3, 3, 4, 4, 1, 2, 0,   0,       1, 0,        0,   0,     16,  2, 16);
    tbl[2] = mk(9, 8, 8, 1, 3, 3, 4, 4, 1, 2, 1,   100,     1, 5,       -1, 100,     16,  2, 0);
    tbl[3] = mk(4, 2, 2, 1, 1, 1, 2, 2, 1, 1, 0,   'h7FFF,  0, 'h7FFF,  -1, 'h7FFF,   0,  0, 4);
    tbl[4] = mk(4, 2, 2, 1, 1, 1, 2, 2, 1, 1, 0,   'h8000,  0, 'h7FFF,  -1, NEG_SAT,  0,  0, 4);

    rst_n = 1'b0; start = 1'b0; fok = 1'b0;
    setup(tbl[0]);
    repeat (3) @(negedge clk);
    chk("rst_re", int'(re), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_fin", int'(fin), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Invalid channel mismatch: straight to DONE with no memory traffic.
    v = tbl[0];
    v.wch = 2;
    setup(v);
    rd0 = n_rd; wr0 = wq_addr.size();
    pulse_start();
    wait_fin(10, cyc);
    chk("inv_fin_within_3", int'(fin && cyc <= 3), 1);
    chk("inv_reads", n_rd - rd0, 0);
    chk("inv_writes", wq_addr.size() - wr0, 0);
    ack("inv");

    // Reset during CONV of the base case: outputs drop at once and stay quiet.
    setup(tbl[0]);
    pulse_start();
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_re", int'(re), 0);
    chk("midrst_we", int'(we), 0);
    chk("midrst_addr", int'(addr), 0);
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_fin", int'(fin), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd0 = n_rd; wr0 = wq_addr.size();
    repeat (30) @(negedge clk);
    chk("midrst_no_reads", n_rd - rd0, 0);
    chk("midrst_no_writes", wq_addr.size() - wr0, 0);

    // After reset, SAME_W=1 must reload: weight memory now has a single 1 at (r=1,k=1).
    v = tbl[1];
    v.same_w = 1; v.if_base = 100; v.w_one_pos = 5; v.exp0 = 109; v.exp_wreads = 16;
    run_vec(v, "postrst_samew");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
